pipeline_stall_controller: RTL

Central stall/flush sequencer for the 5-stage MIPS pipeline. It replaces per-hazard enable logic with one controller that arbitrates four stall sources and drives every pipeline-register write enable and bubble select:
- data-memory wait,
- multi-cycle multiply/divide occupancy of EX,
- load-use dependency,
- taken-branch flush.

It also keeps a saturating count of cycles in which the PC is stalled, for performance observation.

---
 rtl/pipeline_stall_controller_if.sv | 45 ++++
 rtl/pipeline_stall_controller.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_stall_controller_if
// Description : Hazard inputs and pipeline-register enables exchanged between
//               the 5-stage pipeline (master) and the stall controller (slave).
// Revision    : 1.0  initial release
// ============================================================================
interface pipeline_stall_controller_if #(
  parameter int STALL_CNT_W = 16
);
  logic [4:0]             IDRegRs;
  logic [4:0]             IDRegRt;
  logic                   IDUsesRt;
  logic [4:0]             EXRegRt;
  logic                   EXMemRead;
  logic                   BranchTaken;
  logic                   MduStart;
  logic                   MemReq;
  logic                   MemReady;
  logic                   PCWrite;
  logic                   IFIDWrite;
  logic                   IFIDFlush;
  logic                   IDEXWrite;
  logic                   IDEXBubble;
  logic                   EXMEMWrite;
  logic                   EXMEMBubble;
  logic                   MEMWBBubble;
  logic                   MduDone;
  logic [STALL_CNT_W-1:0] stall_cycles;

  modport master (
    output IDRegRs, IDRegRt, IDUsesRt, EXRegRt, EXMemRead, BranchTaken,
           MduStart, MemReq, MemReady,
    input  PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXBubble, EXMEMWrite,
           EXMEMBubble, MEMWBBubble, MduDone, stall_cycles
  );

  modport slave (
    input  IDRegRs, IDRegRt, IDUsesRt, EXRegRt, EXMemRead, BranchTaken,
           MduStart, MemReq, MemReady,
    output PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXBubble, EXMEMWrite,
           EXMEMBubble, MEMWBBubble, MduDone, stall_cycles
  );
endinterface
`default_nettype wire

// File: rtl/pipeline_stall_controller.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_stall_controller
// Description : Arbitrates memory-wait, MDU occupancy, load-use and branch
//               hazards into pipeline write enables / bubbles; counts PC stalls.
// Revision    : 1.0  initial release
// ============================================================================
module pipeline_stall_controller #(
  parameter int MDU_LATENCY = 4,
  parameter int STALL_CNT_W = 16
) (
  input wire clk,
  input wire reset,
  pipeline_stall_controller_if.slave bus
);

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MDU_WAIT = 1'b1
  } state_t;

  localparam logic [7:0]             C_MDU_RELOAD = 8'(MDU_LATENCY - 1);
  localparam logic [STALL_CNT_W-1:0] C_STALL_MAX  = '1;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [7:0]             r_mdu_cnt;
  logic [7:0]             w_mdu_cnt_nxt;
  logic [STALL_CNT_W-1:0] r_stall_cycles;

  logic w_mem_stall;
  logic w_load_use;
  logic w_mdu_freeze;
  logic w_mdu_done;

  logic w_pc_write;
  logic w_ifid_write;
  logic w_ifid_flush;
  logic w_idex_write;
  logic w_idex_bubble;
  logic w_exmem_write;
  logic w_exmem_bubble;
  logic w_memwb_bubble;
  logic w_mdu_done_out;

  assign w_mem_stall = bus.MemReq & ~bus.MemReady;
  assign w_load_use  = bus.EXMemRead & (bus.EXRegRt != 5'd0) &
                       ((bus.EXRegRt == bus.IDRegRs) |
                        (bus.IDUsesRt & (bus.EXRegRt == bus.IDRegRt)));

  // MDU sequencing: the countdown keeps running under a memory stall, but the
  // completion cycle itself waits for the memory stall to clear.
  always_comb begin
    w_state_nxt   = r_state;
    w_mdu_cnt_nxt = r_mdu_cnt;
    w_mdu_freeze  = 1'b0;
    w_mdu_done    = 1'b0;
    case (r_state)
      RUN: begin
        if (bus.MduStart && !w_mem_stall) begin
          w_mdu_freeze  = 1'b1;
          w_state_nxt   = MDU_WAIT;
          w_mdu_cnt_nxt = C_MDU_RELOAD;
        end
      end
      MDU_WAIT: begin
        if (r_mdu_cnt != 8'd0) begin
          w_mdu_freeze  = 1'b1;
          w_mdu_cnt_nxt = r_mdu_cnt - 8'd1;
        end else if (!w_mem_stall) begin
          w_mdu_done  = 1'b1;
          w_state_nxt = RUN;
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  always_comb begin
    w_pc_write     = 1'b1;
    w_ifid_write   = 1'b1;
    w_ifid_flush   = 1'b0;
    w_idex_write   = 1'b1;
    w_idex_bubble  = 1'b0;
    w_exmem_write  = 1'b1;
    w_exmem_bubble = 1'b0;
    w_memwb_bubble = 1'b0;
    w_mdu_done_out = 1'b0;
    if (reset) begin
      w_pc_write     = 1'b0;
      w_ifid_write   = 1'b0;
      w_ifid_flush   = 1'b1;
      w_idex_write   = 1'b0;
      w_idex_bubble  = 1'b1;
      w_exmem_write  = 1'b0;
      w_exmem_bubble = 1'b1;
      w_memwb_bubble = 1'b1;
    end else if (w_mem_stall) begin
      w_pc_write     = 1'b0;
      w_ifid_write   = 1'b0;
      w_idex_write   = 1'b0;
      w_exmem_write  = 1'b0;
      w_memwb_bubble = 1'b1;
    end else begin
      w_mdu_done_out = w_mdu_done;
      if (w_mdu_freeze) begin
        w_pc_write     = 1'b0;
        w_ifid_write   = 1'b0;
        w_idex_write   = 1'b0;
        w_exmem_bubble = 1'b1;
      end else if (w_load_use) begin
        w_pc_write    = 1'b0;
        w_ifid_write  = 1'b0;
        w_idex_bubble = 1'b1;
      end else if (bus.BranchTaken) begin
        w_ifid_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= RUN;
      r_mdu_cnt      <= 8'd0;
      r_stall_cycles <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_mdu_cnt <= w_mdu_cnt_nxt;
      if (!w_pc_write && (r_stall_cycles != C_STALL_MAX)) begin
        r_stall_cycles <= r_stall_cycles + 1'b1;
      end
    end
  end

  assign bus.PCWrite      = w_pc_write;
  assign bus.IFIDWrite    = w_ifid_write;
  assign bus.IFIDFlush    = w_ifid_flush;
  assign bus.IDEXWrite    = w_idex_write;
  assign bus.IDEXBubble   = w_idex_bubble;
  assign bus.EXMEMWrite   = w_exmem_write;
  assign bus.EXMEMBubble  = w_exmem_bubble;
  assign bus.MEMWBBubble  = w_memwb_bubble;
  assign bus.MduDone      = w_mdu_done_out;
  assign bus.stall_cycles = r_stall_cycles;

endmodule
`default_nettype wire
